// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the single memory port.
// Define MEM_ARB_FIXED_PRIORITY_EN to make requester 1 always win a tie.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 26,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data_in,
  input  logic [DATA_W-1:0] i_mem_data_out,
  output logic              o_mem_read,
  output logic              o_mem_write
);

  localparam logic [3:0] CntLoad = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic              r_last;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_cnt;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic              w_any_req;
  logic              w_winner;

  always_comb begin
    w_any_req = i_req0 | i_req1;
    w_winner  = i_req1;
    if (i_req0 && i_req1) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
      w_winner = 1'b1;
`else
      w_winner = ~r_last;
`endif
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_any_req) w_state_d = StAccess;
      StAccess: if (r_cnt == 4'd0) w_state_d = StDone;
      StDone:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StIdle && w_any_req) begin
        r_owner <= w_winner;
        r_last  <= w_winner;
        r_we    <= w_winner ? i_we1 : i_we0;
        r_addr  <= w_winner ? i_addr1 : i_addr0;
        r_wdata <= w_winner ? i_wdata1 : i_wdata0;
        r_cnt   <= CntLoad;
      end
      if (r_state == StAccess) begin
        if (r_cnt != 4'd0) begin
          r_cnt <= r_cnt - 4'd1;
        end else if (!r_we) begin
          // Read data is captured on the final strobe cycle.
          if (r_owner) r_rdata1 <= i_mem_data_out;
          else         r_rdata0 <= i_mem_data_out;
        end
      end
    end
  end

  always_comb begin
    o_gnt0        = 1'b0;
    o_gnt1        = 1'b0;
    o_ack0        = 1'b0;
    o_ack1        = 1'b0;
    o_mem_addr    = '0;
    o_mem_data_in = '0;
    o_mem_read    = 1'b0;
    o_mem_write   = 1'b0;
    if (r_state != StIdle) begin
      o_gnt0 = ~r_owner;
      o_gnt1 = r_owner;
    end
    if (r_state == StAccess) begin
      o_mem_addr  = r_addr;
      o_mem_read  = ~r_we;
      o_mem_write = r_we;
      if (r_we) o_mem_data_in = r_wdata;
    end
    if (r_state == StDone) begin
      o_ack0 = ~r_owner;
      o_ack1 = r_owner;
    end
  end

  assign o_busy   = (r_state != StIdle);
  assign o_rdata0 = r_rdata0;
  assign o_rdata1 = r_rdata1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: cycle vector table plus directed
// sequences for round robin, reset abort and early request drop.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 26;
  localparam int unsigned DW = 32;
  localparam logic [AW-1:0] A0 = 26'h1000000;
  localparam logic [AW-1:0] A1 = 26'h1000001;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, ack0, ack1, busy, mem_read, mem_write;
  logic [DW-1:0] rdata0, rdata1, mem_data_in, mem_data_out;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] mem [0:15];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(2)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req0         (req0),
    .i_req1         (req1),
    .i_we0          (we0),
    .i_we1          (we1),
    .i_addr0        (addr0),
    .i_addr1        (addr1),
    .i_wdata0       (wdata0),
    .i_wdata1       (wdata1),
    .o_gnt0         (gnt0),
    .o_gnt1         (gnt1),
    .o_ack0         (ack0),
    .o_ack1         (ack1),
    .o_rdata0       (rdata0),
    .o_rdata1       (rdata1),
    .o_busy         (busy),
    .o_mem_addr     (mem_addr),
    .o_mem_data_in  (mem_data_in),
    .i_mem_data_out (mem_data_out),
    .o_mem_read     (mem_read),
    .o_mem_write    (mem_write)
  );

  // Small memory model indexed by the low address bits.
  assign mem_data_out = mem[mem_addr[3:0]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[3:0]] <= mem_data_in;
  end

  typedef struct {
    logic          rst;
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic [6:0]    ctrl;   // {gnt0, gnt1, ack0, ack1, busy, mem_read, mem_write}
    logic [AW-1:0] maddr;
    logic [DW-1:0] mdin;
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(input logic r, input logic q0, input logic w0,
                              input logic [AW-1:0] a0, input logic q1, input logic w1,
                              input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic [6:0] c, input logic [AW-1:0] ma,
                              input logic [DW-1:0] md, input logic [DW-1:0] r0,
                              input logic [DW-1:0] r1);
    vec_t v;
    v.rst = r; v.req0 = q0; v.we0 = w0; v.addr0 = a0;
    v.req1 = q1; v.we1 = w1; v.addr1 = a1; v.wdata1 = d1;
    v.ctrl = c; v.maddr = ma; v.mdin = md; v.rd0 = r0; v.rd1 = r1;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [6:0] ctrl_now();
    return {gnt0, gnt1, ack0, ack1, busy, mem_read, mem_write};
  endfunction

  int ack_who [4];
  int ack_cyc [4];
  int n_acks;
  int n_exp;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 32'h0000_0005;
    rst = 1'b1;
    idle_inputs();

    vecs[0]  = mk(1, 0, 0, 0,  0, 0, 0,  0,            7'b0000000, 0,  0,            0, 0);
    vecs[1]  = mk(0, 1, 0, A0, 0, 0, 0,  0,            7'b1000110, A0, 0,            0, 0);
    vecs[2]  = mk(0, 1, 0, A0, 0, 0, 0,  0,            7'b1000110, A0, 0,            0, 0);
    vecs[3]  = mk(0, 1, 0, A0, 0, 0, 0,  0,            7'b1010100, 0,  0,            5, 0);
    vecs[4]  = mk(0, 0, 0, 0,  0, 0, 0,  0,            7'b0000000, 0,  0,            5, 0);
    vecs[5]  = mk(0, 0, 0, 0,  1, 1, A1, 32'hDEADBEEF, 7'b0100101, A1, 32'hDEADBEEF, 5, 0);
    vecs[6]  = mk(0, 0, 0, 0,  1, 1, A1, 32'hDEADBEEF, 7'b0100101, A1, 32'hDEADBEEF, 5, 0);
    vecs[7]  = mk(0, 0, 0, 0,  1, 1, A1, 32'hDEADBEEF, 7'b0101100, 0,  0,            5, 0);
    vecs[8]  = mk(0, 0, 0, 0,  1, 0, A1, 0,            7'b0000000, 0,  0,            5, 0);
    vecs[9]  = mk(0, 0, 0, 0,  1, 0, A1, 0,            7'b0100110, A1, 0,            5, 0);
    vecs[10] = mk(0, 0, 0, 0,  1, 0, A1, 0,            7'b0100110, A1, 0,            5, 0);
    vecs[11] = mk(0, 0, 0, 0,  1, 0, A1, 0,            7'b0101100, 0,  0,            5, 32'hDEADBEEF);
    vecs[12] = mk(0, 0, 0, 0,  0, 0, 0,  0,            7'b0000000, 0,  0,            5, 32'hDEADBEEF);

    for (int i = 0; i < 13; i++) begin
      rst = vecs[i].rst; req0 = vecs[i].req0; we0 = vecs[i].we0; addr0 = vecs[i].addr0;
      req1 = vecs[i].req1; we1 = vecs[i].we1; addr1 = vecs[i].addr1;
      wdata1 = vecs[i].wdata1;
      step();
      check($sformatf("v%0d_ctrl", i), 64'(ctrl_now()), 64'(vecs[i].ctrl));
      check($sformatf("v%0d_mem_addr", i), 64'(mem_addr), 64'(vecs[i].maddr));
      check($sformatf("v%0d_mem_data_in", i), 64'(mem_data_in), 64'(vecs[i].mdin));
      check($sformatf("v%0d_rdata0", i), 64'(rdata0), 64'(vecs[i].rd0));
      check($sformatf("v%0d_rdata1", i), 64'(rdata1), 64'(vecs[i].rd1));
    end

    // Both requesters held continuously.
    do_reset();
    req0 = 1'b1; addr0 = A0; req1 = 1'b1; addr1 = A1;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    n_exp = 3;
`else
    n_exp = 4;
`endif
    n_acks = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      check("gnt_exclusive", 64'(gnt0 & gnt1), 64'd0);
      check("strobe_exclusive", 64'(mem_read & mem_write), 64'd0);
`ifdef MEM_ARB_FIXED_PRIORITY_EN
      check("fixed_no_gnt0", 64'(gnt0), 64'd0);
`endif
      if ((ack0 || ack1) && n_acks < 4) begin
        ack_who[n_acks] = ack1 ? 1 : 0;
        ack_cyc[n_acks] = c;
        n_acks++;
      end
    end
    idle_inputs();
    repeat (4) step();
    check("rr_ack_count", 64'(n_acks >= n_exp), 64'd1);
    for (int k = 0; k < n_exp && k < n_acks; k++) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
      check($sformatf("order_%0d", k), 64'(ack_who[k]), 64'd1);
`else
      check($sformatf("order_%0d", k), 64'(ack_who[k]), 64'(k % 2));
`endif
      if (k > 0) check($sformatf("spacing_%0d", k), 64'(ack_cyc[k] - ack_cyc[k-1]), 64'd4);
    end

    // Reset during the second ACCESS cycle of a write from requester 0.
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = A0 + 26'd2; wdata0 = 32'h1234_5678;
    step();
    check("abort_access1", 64'(ctrl_now()), 64'(7'b1000101));
    step();
    check("abort_access2", 64'({ctrl_now(), mem_data_in}), 64'({7'b1000101, 32'h1234_5678}));
    rst = 1'b1;
    step();
    check("abort_ctrl_zero", 64'(ctrl_now()), 64'd0);
    check("abort_bus_zero", 64'({mem_addr, mem_data_in}), 64'd0);
    check("abort_rdata_zero", 64'({rdata0, rdata1}), 64'd0);
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = A0; req1 = 1'b1; we1 = 1'b0; addr1 = A1;
    step();
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    check("abort_tie_gnt", 64'({gnt0, gnt1}), 64'(2'b01));
`else
    check("abort_tie_gnt", 64'({gnt0, gnt1}), 64'(2'b10));
`endif
    idle_inputs();
    repeat (4) step();

    // Requester 0 drops REQ one cycle after grant.
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = A0;
    step();
    check("drop_gnt0", 64'(gnt0), 64'd1);
    req0 = 1'b0;
    step();
    check("drop_still_access", 64'(ctrl_now()), 64'(7'b1000110));
    step();
    check("drop_ack0", 64'({ack0, rdata0}), 64'({1'b1, 32'h0000_0005}));
    for (int c = 0; c < 6; c++) begin
      step();
      check("drop_no_regrant", 64'({gnt0, busy}), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
